// File: rtl/m_serial_sub.sv
`default_nettype none
// ============================================================================
//  Module      : m_serial_sub
//  Description : Bit-serial unsigned subtractor D = A - B, LSB first, one
//                full-subtractor step per clock, valid/ready on both sides.
//  Revision    : 1.0 - initial release
// ============================================================================
module m_serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             w_clk,
    input  logic             w_rst,
    input  logic             w_in_valid,
    output logic             w_in_ready,
    input  logic [WIDTH-1:0] w_a,
    input  logic [WIDTH-1:0] w_b,
    output logic             w_out_valid,
    input  logic             w_out_ready,
    output logic [WIDTH-1:0] w_d,
    output logic             w_bout,
    output logic             w_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] C_ONE  = CW'(1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_borrow;
    logic [CW-1:0]    r_cnt;

    logic             w_a0;
    logic             w_b0;
    logic             w_dbit;
    logic             w_borrow_nxt;
    logic [WIDTH-1:0] w_res_shift;

    // Full-subtractor step on the current LSBs and the running borrow
    assign w_a0         = r_a[0];
    assign w_b0         = r_b[0];
    assign w_dbit       = w_a0 ^ w_b0 ^ r_borrow;
    assign w_borrow_nxt = (~w_a0 & w_b0) | (~(w_a0 ^ w_b0) & r_borrow);

    generate
        if (WIDTH == 1) begin : g_res_w1
            assign w_res_shift = w_dbit;
        end else begin : g_res_wn
            assign w_res_shift = {w_dbit, r_res[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_in_valid)      w_state_nxt = S_BUSY;
            S_BUSY: if (r_cnt == C_LAST) w_state_nxt = S_DONE;
            S_DONE: if (w_out_ready)     w_state_nxt = S_IDLE;
            default:                     w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            S_IDLE:  w_in_ready  = 1'b1;
            S_DONE:  w_out_valid = 1'b1;
            default: ;
        endcase
    end

    // Operands are captured at accept so later input changes cannot leak in
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_in_valid) begin
                        r_a      <= w_a;
                        r_b      <= w_b;
                        r_res    <= '0;
                        r_borrow <= 1'b0;
                        r_cnt    <= '0;
                    end
                end
                S_BUSY: begin
                    r_a      <= r_a >> 1;
                    r_b      <= r_b >> 1;
                    r_res    <= w_res_shift;
                    r_borrow <= w_borrow_nxt;
                    r_cnt    <= r_cnt + C_ONE;
                end
                default: ;
            endcase
        end
    end

    assign w_d    = r_res;
    assign w_bout = r_borrow;
    assign w_zero = (r_res == '0);

endmodule
`default_nettype wire
